seg7_symbol_rx: RTL and testbench
=================================

Name: seg7_symbol_rx

Overview:
- Receive side of the 7-segment display interface: watches a segment/dp bus driven by a display encoder and recovers the displayed symbol as a 4-bit value.
- Filters glitches by requiring a pattern to be stable before acceptance.
- Emits one event per symbol change through a valid/ready handshake.
- Used by self-check and loopback logic to read back what the display encoders are showing.

Parameters:
- STABLE_CYCLES, 4: consecutive clocks a registered pattern must hold before acceptance. Legal range is 1..255.
- CNT_W, 8: stability counter width. It must hold STABLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- seg_in  input  7  segment bus, active-high; bit6=a, bit5=f, bit4=b, bit3=g, bit2=e, bit1=c, bit0=d
- dp_in  input  1  decimal point, active-high
- out_value  output  4  decoded symbol value
- out_dp  output  1  dp captured with the symbol
- out_err  output  1  accepted pattern is not in the decode table
- out_blank  output  1  accepted pattern is all-zero
- out_valid  output  1  event available
- out_ready  input  1  consumer accepts the event
- overrun  output  1  sticky: an event was dropped
- clr_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst=1): out_value=0, out_dp=0, out_err=0, out_blank=0, out_valid=0, overrun=0. Internal sample register=0, last-accepted pattern=0 (blank, dp=0), stability counter=0.
- Input stage: {dp_in, seg_in} is registered every clock into the sample register (8 bits). No other synchroniser is used; the source shares clk.
- Stability counter:
  - Cleared when the new sample differs from the current sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - When it reaches STABLE_CYCLES and the sample differs from last-accepted, the sample is accepted on that edge.
- Latency: input held constant from edge N is accepted at edge N+STABLE_CYCLES. out_valid is high after edge N+STABLE_CYCLES+1.
- A pattern equal to last-accepted is never re-emitted, however long it is held.
- Decode table (pattern -> value):
  - 1110111->0, 0010010->1, 1011101->2, 1011011->3, 1101011->5
  - 0111010->4, 1101111->6, 1010010->7, 1111111->8, 1111011->9
- Decode results for other patterns:
  - Pattern 0000000: out_blank=1, out_value=0, out_err=0.
  - Any other pattern: out_err=1, out_value=0xF, out_blank=0.
- dp does not affect decode. It is passed to out_dp. A change of dp alone is a new symbol and produces an event.
- Output slot (one entry):
  - Accepted event loads out_* and sets out_valid when the slot is empty, or when out_valid&&out_ready on the same edge (simultaneous pop/push keeps out_valid=1 with the new data).
  - If out_valid=1 and out_ready=0 at acceptance: the new event is dropped and overrun is set. Last-accepted is still updated, so the dropped symbol is not re-emitted.
- out_valid&&out_ready with no acceptance clears out_valid. Data outputs hold their last value.
- Outputs are stable while out_valid=1 and out_ready=0.
- overrun: set by a drop, cleared by clr_overrun. If both occur on the same edge, set wins.
- Reset mid-operation: any partially counted pattern and any pending event are discarded. After release, a blank bus produces no event.

Optional Feature:
- Macro: SEG7_HEX_EN.
- Defined: these letter patterns also decode without error: 1111110->A, 0101111->b, 1100101->C, 0011111->d, 1101101->E, 1101100->F. out_err is then raised only for the remaining patterns. An error still reports out_value=0xF; consumers distinguish it from F via out_err.
- Undefined: those six patterns produce out_err=1.

Test Plan:
- After reset release, hold seg_in=0000000, dp=0, out_ready=1 for 20 cycles -> out_valid stays 0 and all outputs stay 0.
- Apply seg_in=1011011 from edge N, out_ready=1 -> out_valid high after edge N+5 for exactly one cycle, with out_value=3, out_err=0. Holding the pattern 30 more cycles produces no further event.
- Apply 1011101 for 3 cycles, then 1111011 steady -> no event for 2; single event with out_value=9.
- Hold out_ready=0; present 0010010, then 1110111, then 1101111 (each 10 cycles) -> slot holds value 1, overrun=1. Then pulse out_ready -> out_valid drops. Then pulse clr_overrun -> overrun=0.
- Present 0111010 with dp toggling 0->1 (each held 10 cycles) -> two events, both value 4, out_dp=0 then 1.
- Present 1111110 -> value 0xA with out_err=0 when SEG7_HEX_EN is defined; out_err=1 with value 0xF when undefined. Assert rst mid-count -> no event emitted.

Source files
------------

// File: rtl/seg7_symbol_rx.sv
// seg7_symbol_rx: recovers the symbol shown on a 7-segment + dp bus.
// Optional SEG7_HEX_EN adds the A..F letter patterns to the decode table.
module seg7_symbol_rx #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       dp_in,
    output logic [3:0] out_value,
    output logic       out_dp,
    output logic       out_err,
    output logic       out_blank,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun,
    input  logic       clr_overrun
);

    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

    logic [7:0]       din;
    logic [7:0]       sample_q;
    logic [7:0]       last_q;
    logic [7:0]       acc_pat_q;
    logic             acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept_d;
    logic [5:0]       dec;

    logic [3:0]       value_q, value_d;
    logic             dp_q, dp_d;
    logic             err_q, err_d;
    logic             blank_q, blank_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    assign din = {dp_in, seg_in};

    // Pattern -> {value, err, blank}; blank and unknown handled apart.
    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] r;
        r = {4'hF, 2'b10};
        case (p)
            7'b0000000: r = {4'h0, 2'b01};
            7'b1110111: r = {4'h0, 2'b00};
            7'b0010010: r = {4'h1, 2'b00};
            7'b1011101: r = {4'h2, 2'b00};
            7'b1011011: r = {4'h3, 2'b00};
            7'b0111010: r = {4'h4, 2'b00};
            7'b1101011: r = {4'h5, 2'b00};
            7'b1101111: r = {4'h6, 2'b00};
            7'b1010010: r = {4'h7, 2'b00};
            7'b1111111: r = {4'h8, 2'b00};
            7'b1111011: r = {4'h9, 2'b00};
`ifdef SEG7_HEX_EN
            7'b1111110: r = {4'hA, 2'b00};
            7'b0101111: r = {4'hB, 2'b00};
            7'b1100101: r = {4'hC, 2'b00};
            7'b0011111: r = {4'hD, 2'b00};
            7'b1101101: r = {4'hE, 2'b00};
            7'b1101100: r = {4'hF, 2'b00};
`endif
            default:    r = {4'hF, 2'b10};
        endcase
        return r;
    endfunction

    // Stability count: restart on change, saturate once stable.
    always_comb begin
        cnt_d = cnt_q;
        if (din != sample_q) begin
            cnt_d = '0;
        end else if (cnt_q != STABLE_C) begin
            cnt_d = cnt_q + 1'b1;
        end
        accept_d = (cnt_d == STABLE_C) && (din != last_q);
    end

    // Sample register, stability counter and acceptance stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q  <= '0;
            last_q    <= '0;
            acc_pat_q <= '0;
            acc_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sample_q <= din;
            cnt_q    <= cnt_d;
            acc_q    <= accept_d;
            if (accept_d) begin
                last_q    <= din;
                acc_pat_q <= din;
            end
        end
    end

    assign dec = decode(acc_pat_q[6:0]);

    // Single-entry output slot with drop-and-flag on a full slot.
    always_comb begin
        value_d = value_q;
        dp_d    = dp_q;
        err_d   = err_q;
        blank_d = blank_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (clr_overrun) begin
            ovr_d = 1'b0;
        end
        if (acc_q) begin
            if (!valid_q || out_ready) begin
                value_d = dec[5:2];
                err_d   = dec[1];
                blank_d = dec[0];
                dp_d    = acc_pat_q[7];
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            dp_q    <= 1'b0;
            err_q   <= 1'b0;
            blank_q <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            dp_q    <= dp_d;
            err_q   <= err_d;
            blank_q <= blank_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_value = value_q;
    assign out_dp    = dp_q;
    assign out_err   = err_q;
    assign out_blank = blank_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_seg7_symbol_rx.sv
// tb_seg7_symbol_rx: directed and random checks of seg7_symbol_rx.
// Honours SEG7_HEX_EN in its reference decode table.
module tb_seg7_symbol_rx;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       dp_in;
    logic [3:0] out_value;
    logic       out_dp;
    logic       out_err;
    logic       out_blank;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;
    logic       clr_overrun;

    seg7_symbol_rx #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .seg_in(seg_in),
        .dp_in(dp_in),
        .out_value(out_value),
        .out_dp(out_dp),
        .out_err(out_err),
        .out_blank(out_blank),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [6:0] tab  [16];
    logic       have [16];
    logic [7:0] m_runpat;
    int         m_runlen;
    logic [7:0] m_last;
    logic       m_pend;
    logic [7:0] m_pend_pat;
    logic       m_valid, m_ovr, m_dp, m_err, m_blank;
    logic [3:0] m_val;

    // Event bookkeeping
    int         step_no = 0;
    int         nev;
    int         ev_first;
    logic [3:0] ev_val;
    logic       ev_err;
    logic       ev_dp0, ev_dp1;

    function automatic logic [5:0] ref_dec(input logic [6:0] p);
        if (p == 7'd0) return {4'h0, 2'b01};
        for (int i = 0; i < 16; i++) begin
            if (have[i] && tab[i] == p) return {i[3:0], 2'b00};
        end
        return {4'hF, 2'b10};
    endfunction

    task automatic model_reset();
        m_runpat   = 8'h00;
        m_runlen   = 1;
        m_last     = 8'h00;
        m_pend     = 1'b0;
        m_pend_pat = 8'h00;
        m_valid    = 1'b0;
        m_ovr      = 1'b0;
        m_dp       = 1'b0;
        m_err      = 1'b0;
        m_blank    = 1'b0;
        m_val      = 4'h0;
    endtask

    // One clock edge of the reference: slot first, then acceptance.
    task automatic model_edge(input logic [7:0] p, input logic rdy,
                              input logic clr);
        logic drop;
        drop = 1'b0;
        if (m_pend) begin
            if (!m_valid || rdy) begin
                {m_val, m_err, m_blank} = ref_dec(m_pend_pat[6:0]);
                m_dp    = m_pend_pat[7];
                m_valid = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (p == m_runpat) begin
            if (m_runlen < 1000) m_runlen++;
        end else begin
            m_runpat = p;
            m_runlen = 1;
        end
        m_pend = (m_runlen == S + 1) && (p != m_last);
        if (m_pend) begin
            m_last     = p;
            m_pend_pat = p;
        end
    endtask

    task automatic check(input string tag);
        logic [8:0] got, exp;
        got = {out_valid, overrun, out_value, out_dp, out_err, out_blank};
        exp = {m_valid, m_ovr, m_val, m_dp, m_err, m_blank};
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic [6:0] s, input logic d, input logic r,
                        input logic c, input string tag);
        seg_in      = s;
        dp_in       = d;
        out_ready   = r;
        clr_overrun = c;
        @(posedge clk);
        model_edge({d, s}, r, c);
        step_no++;
        #1;
        check(tag);
        if (out_valid) begin
            if (nev == 0) begin
                ev_first = step_no;
                ev_dp0   = out_dp;
            end
            ev_dp1 = out_dp;
            ev_val = out_value;
            ev_err = out_err;
            nev++;
        end
    endtask

    task automatic hold(input logic [6:0] s, input logic d, input logic r,
                        input int n, input string tag);
        for (int i = 0; i < n; i++) step(s, d, r, 1'b0, tag);
    endtask

    initial begin
        int base;
        int len;
        logic [6:0] p;
        logic d, r, c;

        tab[0]  = 7'b1110111; tab[1]  = 7'b0010010;
        tab[2]  = 7'b1011101; tab[3]  = 7'b1011011;
        tab[4]  = 7'b0111010; tab[5]  = 7'b1101011;
        tab[6]  = 7'b1101111; tab[7]  = 7'b1010010;
        tab[8]  = 7'b1111111; tab[9]  = 7'b1111011;
        tab[10] = 7'b1111110; tab[11] = 7'b0101111;
        tab[12] = 7'b1100101; tab[13] = 7'b0011111;
        tab[14] = 7'b1101101; tab[15] = 7'b1101100;
        for (int i = 0; i < 16; i++) begin
`ifdef SEG7_HEX_EN
            have[i] = 1'b1;
`else
            have[i] = (i < 10);
`endif
        end

        rst         = 1'b1;
        seg_in      = 7'd0;
        dp_in       = 1'b0;
        out_ready   = 1'b1;
        clr_overrun = 1'b0;
        nev         = 0;
        ev_first    = -1;
        model_reset();
        #12;
        check("reset");
        rst = 1'b0;

        // Idle blank bus
        nev = 0;
        hold(7'd0, 1'b0, 1'b1, 20, "idle");
        chk("idle_events", nev, 0);

        // Digit 3: latency and no re-emit while held
        nev = 0;
        base = step_no;
        hold(7'b1011011, 1'b0, 1'b1, 36, "three");
        chk("three_events", nev, 1);
        chk("three_latency", ev_first, base + S + 2);
        chk("three_value", ev_val, 3);
        chk("three_err", ev_err, 0);

        // Short glitch of 2, then steady 9
        nev = 0;
        hold(7'b1011101, 1'b0, 1'b1, 3, "glitch");
        hold(7'b1111011, 1'b0, 1'b1, 20, "nine");
        chk("nine_events", nev, 1);
        chk("nine_value", ev_val, 9);

        // Backpressure: first event kept, later ones dropped
        hold(7'b0010010, 1'b0, 1'b0, 10, "bp1");
        hold(7'b1110111, 1'b0, 1'b0, 10, "bp0");
        hold(7'b1101111, 1'b0, 1'b0, 10, "bp6");
        chk("bp_valid", out_valid, 1);
        chk("bp_value", out_value, 1);
        chk("bp_overrun", overrun, 1);
        step(7'b1101111, 1'b0, 1'b1, 1'b0, "pop");
        chk("pop_valid", out_valid, 0);
        chk("pop_overrun", overrun, 1);
        step(7'b1101111, 1'b0, 1'b0, 1'b1, "clr");
        chk("clr_overrun", overrun, 0);
        hold(7'b1101111, 1'b0, 1'b1, 10, "bp_tail");

        // dp alone makes a new symbol
        nev = 0;
        hold(7'b0111010, 1'b0, 1'b1, 10, "four_dp0");
        hold(7'b0111010, 1'b1, 1'b1, 10, "four_dp1");
        chk("dp_events", nev, 2);
        chk("dp_value", ev_val, 4);
        chk("dp_first", ev_dp0, 0);
        chk("dp_second", ev_dp1, 1);

        // Letter A pattern
        nev = 0;
        hold(7'b1111110, 1'b0, 1'b1, 10, "letterA");
        chk("A_events", nev, 1);
`ifdef SEG7_HEX_EN
        chk("A_value", ev_val, 10);
        chk("A_err", ev_err, 0);
`else
        chk("A_value", ev_val, 15);
        chk("A_err", ev_err, 1);
`endif

        // Reset mid-count, then blank bus
        nev = 0;
        hold(7'b0010010, 1'b0, 1'b1, 2, "precount");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("midreset");
        #3;
        rst = 1'b0;
        hold(7'd0, 1'b0, 1'b1, 12, "post_reset");
        chk("reset_events", nev, 0);

        // Random runs against the reference
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0:       p = 7'd0;
                1:       p = 7'($urandom);
                default: p = tab[$urandom_range(0, 15)];
            endcase
            d   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                r = ($urandom_range(0, 9) < 7);
                c = ($urandom_range(0, 19) == 0);
                step(p, d, r, c, "random");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
